// File: rtl/spi_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_reg_ctrl
// Description : SPI mode-0 write-only register file (16-bit frames, five 8-bit
//               registers). Optional SPI_FRAME_ERR_EN adds a frame_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MAX_ADDR    = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_SHIFT  = 1'b1;
    localparam logic [4:0] c_CNT_OK = 5'd16;
    localparam logic [4:0] c_CNT_MX = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic [SYNC_STAGES-1:0] flush_q,     flush_d;
    logic                   sclk_dly_q,  sclk_dly_d;
    logic                   ncs_dly_q,   ncs_dly_d;
    logic                   armed_q,     armed_d;
    logic [0:0]             state_q,     state_d;
    logic [4:0]             bit_cnt_q,   bit_cnt_d;
    logic [15:0]            shreg_q,     shreg_d;
    logic [7:0]             regs_q [0:4];
    logic [7:0]             regs_d [0:4];

    logic w_sclk_s, w_copi_s, w_ncs_s;
    logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
    logic w_start, w_end, w_shift, w_commit;

    assign w_sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign w_copi_s = copi_sync_q[SYNC_STAGES-1];
    assign w_ncs_s  = ncs_sync_q[SYNC_STAGES-1];

    // A fall is only trusted once ncs has been seen high after reset, so a
    // frame cut by reset cannot resume when the reset value drains out.
    assign w_sclk_rise = w_sclk_s & ~sclk_dly_q;
    assign w_ncs_rise  = w_ncs_s & ~ncs_dly_q;
    assign w_ncs_fall  = armed_q & ncs_dly_q & ~w_ncs_s;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
        sclk_dly_d  = w_sclk_s;
        ncs_dly_d   = w_ncs_s;
        armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & w_ncs_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            flush_q     <= '0;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            flush_q     <= flush_d;
            sclk_dly_q  <= sclk_dly_d;
            ncs_dly_q   <= ncs_dly_d;
            armed_q     <= armed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_ncs_fall) state_d = c_SHIFT;
            c_SHIFT: if (w_ncs_rise) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ncs rise takes priority over a coincident sclk rise.
    always_comb begin
        w_start = (state_q == c_IDLE) && w_ncs_fall;
        w_end   = (state_q == c_SHIFT) && w_ncs_rise;
        w_shift = (state_q == c_SHIFT) && w_sclk_rise && !w_ncs_rise;
    end

    assign w_commit = w_end && (bit_cnt_q == c_CNT_OK) && shreg_q[15]
                      && ({1'b0, shreg_q[14:8]} <= MAX_ADDR);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (w_start) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (w_shift) begin
            shreg_d = {shreg_q[14:0], w_copi_s};
            if (bit_cnt_q != c_CNT_MX) bit_cnt_d = bit_cnt_q + 5'd1;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (w_commit) begin
            case (shreg_q[14:8])
                7'd0:    regs_d[0] = shreg_q[7:0];
                7'd1:    regs_d[1] = shreg_q[7:0];
                7'd2:    regs_d[2] = shreg_q[7:0];
                7'd3:    regs_d[3] = shreg_q[7:0];
                7'd4:    regs_d[4] = shreg_q[7:0];
                default: regs_d = regs_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            regs_q    <= '{default: 8'h00};
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            regs_q    <= regs_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    assign frame_err_d = w_end && (bit_cnt_q != c_CNT_OK);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_ctrl
// Description : Scoreboard bench for spi_reg_ctrl with directed SPI frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    localparam int SS = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs  = 1'b1;
    logic [7:0] r0, r1, r2, r3, r4;
`ifdef SPI_FRAME_ERR_EN
    logic frame_err;
`endif

    always #5 clk = ~clk;

    spi_reg_ctrl #(.SYNC_STAGES(SS), .MAX_ADDR(8'h04)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err       (frame_err)
`endif
    );

    typedef struct packed {
        logic [39:0] prev;
        logic [39:0] next;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m [5];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 1'b0;

    function automatic logic [39:0] model_regs();
        return {m[0], m[1], m[2], m[3], m[4]};
    endfunction

    function automatic logic [39:0] dut_regs();
        return {r0, r1, r2, r3, r4};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit commit, input int addr, input logic [7:0] data, input bit err);
        exp_t e;
        e.prev = model_regs();
        if (commit) m[addr] = data;
        e.next = model_regs();
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic send_bits(input logic [47:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = d[i];
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // sim=1 raises sclk on the same clk as ncs so both edges land together.
    task automatic frame(input logic [47:0] d, input int n, input bit sim, input int gap);
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        send_bits(d, n);
        repeat (2) @(negedge clk);
        if (sim) sclk = 1'b1;
        ncs = 1'b1;
        if (sim) begin
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: each ncs rise must leave registers untouched for SS edges and
    // present the new state after edge SS+1.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge ncs);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got=ncs_rise expected=queued_frame at %0t", $time);
            end else begin
                e = sb.pop_front();
                repeat (SS) @(posedge clk);
                @(negedge clk);
                chk("regs_before_commit", dut_regs(), e.prev);
`ifdef SPI_FRAME_ERR_EN
                chk("frame_err_before", {39'b0, frame_err}, 40'd0);
`endif
                @(posedge clk);
                @(negedge clk);
                chk("regs_after_commit", dut_regs(), e.next);
`ifdef SPI_FRAME_ERR_EN
                chk("frame_err_pulse", {39'b0, frame_err}, {39'b0, e.err});
                @(negedge clk);
                chk("frame_err_one_cycle", {39'b0, frame_err}, 40'd0);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m[i]) m[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_7_0",  {32'b0, r0}, 40'd0);
        chk("reset_out_15_8", {32'b0, r1}, 40'd0);
        chk("reset_pwm_7_0",  {32'b0, r2}, 40'd0);
        chk("reset_pwm_15_8", {32'b0, r3}, 40'd0);
        chk("reset_duty",     {32'b0, r4}, 40'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("reset_frame_err", {39'b0, frame_err}, 40'd0);
`endif
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        push_exp(1, 4, 8'h80, 0); frame(48'h8480, 16, 0, 8);
        push_exp(0, 0, 8'h00, 0); frame(48'h85AA, 16, 0, 8);
        push_exp(0, 0, 8'h00, 0); frame(48'h00FF, 16, 0, 8);
        push_exp(0, 0, 8'h00, 1); frame(48'h407F, 15, 0, 8);
        push_exp(0, 0, 8'h00, 1); frame(48'h101FF, 17, 0, 8);
        push_exp(0, 0, 8'h00, 1); frame(48'h80FF80FF80FF, 48, 0, 8);
        push_exp(1, 3, 8'h77, 0); frame(48'h8377, 16, 1, 8);
        push_exp(1, 2, 8'h11, 0); frame(48'h8211, 16, 0, 1);
        push_exp(1, 3, 8'h22, 0); frame(48'h8322, 16, 0, 8);
        push_exp(1, 1, 8'h3C, 0); frame(48'h813C, 16, 0, 8);

        // Reset cuts a write to 0x01 halfway; the tail must not be counted.
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        send_bits(48'h81, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        foreach (m[i]) m[i] = 8'h00;
        chk("regs_after_mid_reset", dut_regs(), 40'd0);
        send_bits(48'h99, 8);
        repeat (2) @(negedge clk);
        push_exp(0, 0, 8'h00, 0);
        ncs = 1'b1;
        repeat (8) @(negedge clk);

        push_exp(1, 0, 8'hF0, 0); frame(48'h80F0, 16, 0, 8);

        repeat (10) @(negedge clk);
        chk("sb_drained", 40'(sb.size()), 40'd0);
        chk("final_out_7_0",  {32'b0, r0}, 40'hF0);
        chk("final_out_15_8", {32'b0, r1}, 40'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of clk flops synchronising sclk, copi and ncs (legal 2-3).
REQ-002 SHALL have parameter MAX_ADDR, default 8'h04, highest writable register address.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk, mode 0.
REQ-006 copi  input  1  SPI controller-out/peripheral-in data, asynchronous.
REQ-007 ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-008 en_reg_out_7_0  output  8  output-enable bits for outputs 7..0 (addr 0x00).
REQ-009 en_reg_out_15_8  output  8  output-enable bits for outputs 15..8 (addr 0x01).
REQ-010 en_reg_pwm_7_0  output  8  PWM-mode select for outputs 7..0 (addr 0x02).
REQ-011 en_reg_pwm_15_8  output  8  PWM-mode select for outputs 15..8 (addr 0x03).
REQ-012 pwm_duty_cycle  output  8  shared PWM duty value, 0x00=0%, 0xFF=100% (addr 0x04).
REQ-013 frame_err  output  1  present only with SPI_FRAME_ERR_EN (REQ-034).

Function
REQ-014 sclk, copi, ncs SHALL each pass through SYNC_STAGES flops; all logic SHALL use only synchronised copies.
REQ-015 Edge detection SHALL compare synchronised value with one further registered copy: sclk rise, ncs fall, ncs rise.
REQ-016 Frame: 16 bits MSB first; bit15 R/W (1=write), bits14:8 address, bits7:0 data.
REQ-017 FSM states IDLE, SHIFT; IDLE->SHIFT on ncs fall; SHIFT->IDLE on ncs rise.
REQ-018 In SHIFT, each sclk rise SHALL shift synchronised copi into a 16-bit shift register LSB and increment a 5-bit bit counter.
REQ-019 Bit counter SHALL saturate at 17; never wraps (32/48-bit frames remain invalid).
REQ-020 ncs fall SHALL clear bit counter and shift register.
REQ-021 On ncs rise, frame SHALL commit iff bit count ==16, bit15==1, address<=MAX_ADDR.
REQ-022 Committed data SHALL appear on the addressed output after exactly SYNC_STAGES+1 clk rising edges following the ncs pin rise.
REQ-023 Read frames (bit15==0), out-of-range addresses, and count !=16 SHALL be discarded; no register changes.
REQ-024 sclk edges while in IDLE SHALL be ignored.
REQ-025 sclk rise and ncs rise detected in same cycle: ncs rise wins; that sclk edge not counted.
REQ-026 Only one register SHALL change per committed frame; others hold.
REQ-027 Outputs SHALL be driven directly from flops (no combinational path from inputs).
REQ-028 Design SHALL tolerate sclk up to clk/4 (SYNC_STAGES=2).

Reset
REQ-029 While rst==1 at a clk edge: all five registers SHALL be 8'h00, FSM IDLE, counter 0, shift register 0, sync chains 1 for ncs and 0 for sclk/copi.
REQ-030 frame_err (if present) SHALL reset to 0.
REQ-031 rst asserted mid-frame SHALL abort the frame; after release a new ncs fall is required before any bit is counted.
REQ-032 Frame whose ncs rise occurs during rst SHALL not commit.

Configuration
REQ-033 Macro SPI_FRAME_ERR_EN SHALL control frame-error reporting.
REQ-034 With SPI_FRAME_ERR_EN defined: port frame_err exists and pulses high for exactly one clk cycle, same cycle as the commit would occur, when ncs rises with bit count !=16; read/out-of-range frames do not pulse it.
REQ-035 Without SPI_FRAME_ERR_EN: port frame_err absent; all other behaviour identical.

Verification
REQ-036 Reset: assert rst 2 cycles -> all five outputs 0x00, frame_err 0.
REQ-037 Write 0x8480 hmm-free form: frame {1,7'h04,8'h80} -> pwm_duty_cycle=0x80 at SYNC_STAGES+1 edges after ncs rise; others 0x00.
REQ-038 Frame {1,7'h05,8'hAA} then {0,7'h00,8'hFF} -> no output changes.
REQ-039 15-bit and 17-bit frames to addr 0x00 data 0xFF -> en_reg_out_7_0 stays 0x00; frame_err pulses once each (macro on).
REQ-040 Write 0x01<=0x3C, assert rst mid next frame to 0x01, release, write 0x00<=0xF0 -> en_reg_out_15_8=0x00, en_reg_out_7_0=0xF0.
REQ-041 Back-to-back writes 0x02<=0x11, 0x03<=0x22 with one clk idle gap at sclk=clk/4 -> both registers hold 0x11, 0x22.
